// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: register-file
// geometry, the writeback entry layout and source indices.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned XLEN       = 64;

  localparam int unsigned SRC_EXE = 0;
  localparam int unsigned SRC_MEM = 1;

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_hold_buf.sv
// One-entry writeback holding buffer with valid/ready handshake; a buffer
// drained this cycle may be refilled on the same edge.
module wb_hold_buf
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = regfile_wb_arbiter_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_data,
  input  logic                  grant,
  output logic                  in_ready,
  output logic                  accept,
  output logic                  vld,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       data
);

  logic                  vld_q, vld_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       data_q, data_d;

  always_comb begin
    in_ready = !vld_q || grant;
    accept   = in_valid && in_ready;
    vld_d    = vld_q;
    rd_d     = rd_q;
    data_d   = data_q;
    if (accept) begin
      vld_d  = 1'b1;
      rd_d   = in_rd;
      data_d = in_data;
    end else if (grant) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign vld  = vld_q;
  assign rd   = rd_q;
  assign data = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the execute and load writeback
// sources with oldest-first arbitration, a RAW pending mask and a conflict counter.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned XLEN  = regfile_wb_arbiter_pkg::XLEN,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src0_valid,
  input  logic [REG_ADDR_W-1:0] src0_rd,
  input  logic [XLEN-1:0]       src0_data,
  output logic                  src0_ready,
  input  logic                  src1_valid,
  input  logic [REG_ADDR_W-1:0] src1_rd,
  input  logic [XLEN-1:0]       src1_data,
  output logic                  src1_ready,
  output logic                  rf_reg_write,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  output logic [XLEN-1:0]       rf_rd_data,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [CNT_W-1:0]      conflict_cnt
);

  logic [1:0]            grant;
  logic [1:0]            accept;
  logic [1:0]            vld;
  logic [REG_ADDR_W-1:0] rd   [2];
  logic [XLEN-1:0]       data [2];

  // 1: buf1 (load) holds the older result when both are occupied
  logic                  mem_older_q, mem_older_d;
  logic [CNT_W-1:0]      conflict_cnt_q, conflict_cnt_d;

  wb_hold_buf #(.XLEN(XLEN)) u_buf_exe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (src0_valid),
    .in_rd    (src0_rd),
    .in_data  (src0_data),
    .grant    (grant[SRC_EXE]),
    .in_ready (src0_ready),
    .accept   (accept[SRC_EXE]),
    .vld      (vld[SRC_EXE]),
    .rd       (rd[SRC_EXE]),
    .data     (data[SRC_EXE])
  );

  wb_hold_buf #(.XLEN(XLEN)) u_buf_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (src1_valid),
    .in_rd    (src1_rd),
    .in_data  (src1_data),
    .grant    (grant[SRC_MEM]),
    .in_ready (src1_ready),
    .accept   (accept[SRC_MEM]),
    .vld      (vld[SRC_MEM]),
    .rd       (rd[SRC_MEM]),
    .data     (data[SRC_MEM])
  );

  always_comb begin
    grant          = '0;
    grant[SRC_MEM] = vld[SRC_MEM] && (!vld[SRC_EXE] || mem_older_q);
    grant[SRC_EXE] = vld[SRC_EXE] && !grant[SRC_MEM];

    rf_reg_write = 1'b0;
    rf_rd_addr   = '0;
    rf_rd_data   = '0;
    if (grant[SRC_MEM]) begin
      rf_reg_write = rd[SRC_MEM] != '0;
      rf_rd_addr   = rd[SRC_MEM];
      rf_rd_data   = data[SRC_MEM];
    end else if (grant[SRC_EXE]) begin
      rf_reg_write = rd[SRC_EXE] != '0;
      rf_rd_addr   = rd[SRC_EXE];
      rf_rd_data   = data[SRC_EXE];
    end

    pending_mask = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (vld[i] && rd[i] != '0) pending_mask[rd[i]] = 1'b1;
    end
  end

  // A fresh fill is younger than whatever stays held across the same edge;
  // simultaneous fills make the load older.
  always_comb begin
    mem_older_d = mem_older_q;
    if (accept[SRC_EXE] && accept[SRC_MEM])
      mem_older_d = 1'b1;
    else if (accept[SRC_EXE] && vld[SRC_MEM] && !grant[SRC_MEM])
      mem_older_d = 1'b1;
    else if (accept[SRC_MEM] && vld[SRC_EXE] && !grant[SRC_EXE])
      mem_older_d = 1'b0;

    conflict_cnt_d = conflict_cnt_q;
    if (vld[SRC_EXE] && vld[SRC_MEM] && conflict_cnt_q != '1)
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_older_q    <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      mem_older_q    <= mem_older_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter plus hand-written
// sequences for throughput, counter saturation and asynchronous reset.
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             src0_valid, src1_valid;
  logic [4:0]       src0_rd, src1_rd;
  logic [XLEN-1:0]  src0_data, src1_data;
  logic             src0_ready, src1_ready;
  logic             rf_reg_write;
  logic [4:0]       rf_rd_addr;
  logic [XLEN-1:0]  rf_rd_data;
  logic [31:0]      pending_mask;
  logic [CNT_W-1:0] conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src0_valid   (src0_valid),
    .src0_rd      (src0_rd),
    .src0_data    (src0_data),
    .src0_ready   (src0_ready),
    .src1_valid   (src1_valid),
    .src1_rd      (src1_rd),
    .src1_data    (src1_data),
    .src1_ready   (src1_ready),
    .rf_reg_write (rf_reg_write),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .pending_mask (pending_mask),
    .conflict_cnt (conflict_cnt)
  );

  typedef struct {
    logic        s0v;
    logic [4:0]  s0rd;
    logic [63:0] s0d;
    logic        s1v;
    logic [4:0]  s1rd;
    logic [63:0] s1d;
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [31:0] mask;
    logic        r0;
    logic        r1;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] rd0, input logic [63:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [63:0] d1);
    src0_valid = v0; src0_rd = rd0; src0_data = d0;
    src1_valid = v1; src1_rd = rd1; src1_data = d1;
  endtask

  function automatic vec_t mk(input logic s0v, input logic [4:0] s0rd, input logic [63:0] s0d,
                              input logic s1v, input logic [4:0] s1rd, input logic [63:0] s1d,
                              input logic we, input logic [4:0] addr, input logic [63:0] data,
                              input logic [31:0] mask, input logic r0, input logic r1,
                              input logic [3:0] cnt);
    vec_t v;
    v.s0v = s0v; v.s0rd = s0rd; v.s0d = s0d;
    v.s1v = s1v; v.s1rd = s1rd; v.s1d = s1d;
    v.we = we; v.addr = addr; v.data = data; v.mask = mask;
    v.r0 = r0; v.r1 = r1; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    //           s0v rd  data    s1v rd  data      we addr data     mask        r0 r1 cnt
    vecs[0]  = mk(0, 0,  0,      0, 0,  0,        0, 0,  0,       32'h0,      1, 1, 0);
    vecs[1]  = mk(1, 7,  'h1234, 0, 0,  0,        0, 0,  0,       32'h0,      1, 1, 0);
    vecs[2]  = mk(0, 0,  0,      0, 0,  0,        1, 7,  'h1234,  32'h80,     1, 1, 0);
    vecs[3]  = mk(0, 0,  0,      0, 0,  0,        0, 0,  0,       32'h0,      1, 1, 0);
    vecs[4]  = mk(1, 4,  'hAA,   1, 4,  'hBB,     0, 0,  0,       32'h0,      1, 1, 0);
    vecs[5]  = mk(0, 0,  0,      0, 0,  0,        1, 4,  'hBB,    32'h10,     0, 1, 0);
    vecs[6]  = mk(0, 0,  0,      0, 0,  0,        1, 4,  'hAA,    32'h10,     1, 1, 1);
    vecs[7]  = mk(0, 0,  0,      0, 0,  0,        0, 0,  0,       32'h0,      1, 1, 1);
    vecs[8]  = mk(0, 0,  0,      1, 0,  'hFFFF,   0, 0,  0,       32'h0,      1, 1, 1);
    vecs[9]  = mk(0, 0,  0,      0, 0,  0,        0, 0,  'hFFFF,  32'h0,      1, 1, 1);
    vecs[10] = mk(1, 5,  'h55,   0, 0,  0,        0, 0,  0,       32'h0,      1, 1, 1);
    vecs[11] = mk(1, 6,  'h66,   1, 9,  'h99,     1, 5,  'h55,    32'h20,     1, 1, 1);
    vecs[12] = mk(0, 0,  0,      0, 0,  0,        1, 9,  'h99,    32'h240,    0, 1, 1);
    vecs[13] = mk(0, 0,  0,      0, 0,  0,        1, 6,  'h66,    32'h40,     1, 1, 2);
    vecs[14] = mk(0, 0,  0,      0, 0,  0,        0, 0,  0,       32'h0,      1, 1, 2);
    vecs[15] = mk(1, 12, 'hC0,   1, 10, 'hA0,     0, 0,  0,       32'h0,      1, 1, 2);
    vecs[16] = mk(0, 0,  0,      1, 11, 'hB0,     1, 10, 'hA0,    32'h1400,   0, 1, 2);
    vecs[17] = mk(0, 0,  0,      0, 0,  0,        1, 12, 'hC0,    32'h1800,   1, 0, 3);
    vecs[18] = mk(0, 0,  0,      0, 0,  0,        1, 11, 'hB0,    32'h800,    1, 1, 4);
    vecs[19] = mk(0, 0,  0,      0, 0,  0,        0, 0,  0,       32'h0,      1, 1, 4);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_we", 64'(rf_reg_write), 0);
    chk("rst_mask", 64'(pending_mask), 0);
    chk("rst_rdy", {62'b0, src0_ready, src1_ready}, 64'h3);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].s0v, vecs[i].s0rd, vecs[i].s0d, vecs[i].s1v, vecs[i].s1rd, vecs[i].s1d);
      @(negedge clk);
      chk($sformatf("v%0d_we", i),   64'(rf_reg_write), 64'(vecs[i].we));
      chk($sformatf("v%0d_addr", i), 64'(rf_rd_addr),   64'(vecs[i].addr));
      chk($sformatf("v%0d_data", i), rf_rd_data,        vecs[i].data);
      chk($sformatf("v%0d_mask", i), 64'(pending_mask), 64'(vecs[i].mask));
      chk($sformatf("v%0d_rdy0", i), 64'(src0_ready),   64'(vecs[i].r0));
      chk($sformatf("v%0d_rdy1", i), 64'(src1_ready),   64'(vecs[i].r1));
      chk($sformatf("v%0d_cnt", i),  64'(conflict_cnt), 64'(vecs[i].cnt));
      @(posedge clk); #1;
    end

    // back-to-back stream on src0: one write per cycle, addresses 1..8
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1, 5'(i + 1), 64'h100 + 64'(i + 1), 0, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("bb%0d_rdy0", i), 64'(src0_ready), 1);
      if (i >= 1) begin
        chk($sformatf("bb%0d_we", i),   64'(rf_reg_write), 1);
        chk($sformatf("bb%0d_addr", i), 64'(rf_rd_addr),   64'(i));
        chk($sformatf("bb%0d_data", i), rf_rd_data,        64'h100 + 64'(i));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bb_idle_we", 64'(rf_reg_write), 0);
    @(posedge clk); #1;

    // keep both buffers occupied long enough to saturate the counter
    for (int i = 0; i < 22; i++) begin
      drive(1, 5'd2, 64'(i), 1, 5'd3, 64'(i + 100));
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sat_cnt", 64'(conflict_cnt), 64'd15);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", 64'(conflict_cnt), 64'd15);
    chk("sat_drained", 64'(pending_mask), 0);

    // asynchronous reset mid-cycle while buf0 holds x3
    drive(1, 5'd3, 64'h3333, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    chk("ar_pre_mask", 64'(pending_mask), 64'h8);
    chk("ar_pre_we", 64'(rf_reg_write), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_we", 64'(rf_reg_write), 0);
    chk("ar_addr", 64'(rf_rd_addr), 0);
    chk("ar_data", rf_rd_data, 0);
    chk("ar_mask", 64'(pending_mask), 0);
    chk("ar_cnt", 64'(conflict_cnt), 0);
    chk("ar_rdy", {62'b0, src0_ready, src1_ready}, 64'h3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("ar_post%0d_we", i), 64'(rf_reg_write), 0);
      chk($sformatf("ar_post%0d_mask", i), 64'(pending_mask), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
